// File: rtl/ex_stage_muldiv_if.sv
// Signal bundle between the ID/EX register and the execute stage.
// The master drives the instruction fields, and the slave returns the EX/Mem register contents and the mult/div status.
interface ex_stage_muldiv_if;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm32;
    logic        src_b_imm;
    logic [4:0]  shamt;
    logic [31:0] pc_in;
    logic [4:0]  waddr_in;
    logic [2:0]  tnew_in;
    logic [31:0] dm_wdata_in;

    logic [31:0] alu_out_ex_to_mem;
    logic [31:0] dm_wdata_ex_to_mem;
    logic [31:0] pc_ex_to_mem;
    logic [4:0]  waddr_ex_to_mem;
    logic [2:0]  tnew_ex_to_mem;
    logic        md_busy;
    logic        md_stall;

    modport master (
        output op, rs_val, rt_val, imm32, src_b_imm, shamt, pc_in, waddr_in, tnew_in, dm_wdata_in,
        input  alu_out_ex_to_mem, dm_wdata_ex_to_mem, pc_ex_to_mem, waddr_ex_to_mem,
               tnew_ex_to_mem, md_busy, md_stall
    );

    modport slave (
        input  op, rs_val, rt_val, imm32, src_b_imm, shamt, pc_in, waddr_in, tnew_in, dm_wdata_in,
        output alu_out_ex_to_mem, dm_wdata_ex_to_mem, pc_ex_to_mem, waddr_ex_to_mem,
               tnew_ex_to_mem, md_busy, md_stall
    );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage: the ALU and the EX/Mem pipeline register, plus a multi-cycle mult/div unit that owns HI/LO.
// The mult/div result is computed at start and held as pending until the busy window ends.
module ex_stage_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
    input logic             clk,
    input logic             reset,
    ex_stage_muldiv_if.slave ex
);
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_ADDU = 4'd1,  OP_SUBU = 4'd2,  OP_OR    = 4'd3,
        OP_LUI  = 4'd4,  OP_SLL  = 4'd5,  OP_LINK = 4'd6,  OP_MULT  = 4'd7,
        OP_MULTU = 4'd8, OP_DIV  = 4'd9,  OP_DIVU = 4'd10, OP_MFHI  = 4'd11,
        OP_MFLO = 4'd12, OP_MTHI = 4'd13, OP_MTLO = 4'd14, OP_NOP15 = 4'd15
    } op_e;

    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    op_e         op;
    logic [31:0] src_a, src_b, alu_res;
    logic        is_md, md_start, stall;

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    assign op       = op_e'(ex.op);
    assign src_a    = ex.rs_val;
    assign src_b    = ex.src_b_imm ? ex.imm32 : ex.rt_val;
    assign is_md    = ex.op inside {[4'd7:4'd14]};
    assign stall    = is_md && (state_q == MD_RUN);
    assign md_start = (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) && (state_q == MD_IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_res = '0;
        case (op)
            OP_ADDU: alu_res = src_a + src_b;
            OP_SUBU: alu_res = src_a - src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_LUI:  alu_res = {src_b[15:0], 16'h0000};
            OP_SLL:  alu_res = ex.rt_val << ex.shamt;
            OP_LINK: alu_res = ex.pc_in + 32'd8;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'h0, src_a} * {32'h0, src_b};

    logic        div_zero;
    logic [31:0] divisor, abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign div_zero = (src_b == 32'h0);
    assign divisor  = div_zero ? 32'd1 : src_b;
    assign abs_a    = src_a[31] ? -src_a : src_a;
    assign abs_b    = divisor[31] ? -divisor : divisor;
    assign q_mag    = abs_a / abs_b;
    assign r_mag    = abs_a % abs_b;
    assign q_s      = (src_a[31] ^ divisor[31]) ? -q_mag : q_mag;
    assign r_s      = src_a[31] ? -r_mag : r_mag;
    assign q_u      = src_a / divisor;
    assign r_u      = src_a % divisor;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d   = MD_RUN;
                    pend_wr_d = 1'b1;
                    case (op)
                        OP_MULT:  begin {pend_hi_d, pend_lo_d} = prod_s; cnt_d = MULT_LOAD; end
                        OP_MULTU: begin {pend_hi_d, pend_lo_d} = prod_u; cnt_d = MULT_LOAD; end
                        OP_DIV:   begin pend_hi_d = r_s; pend_lo_d = q_s; pend_wr_d = !div_zero; cnt_d = DIV_LOAD; end
                        default:  begin pend_hi_d = r_u; pend_lo_d = q_u; pend_wr_d = !div_zero; cnt_d = DIV_LOAD; end
                    endcase
                end else if (op == OP_MTHI) begin
                    hi_d = ex.rs_val;
                end else if (op == OP_MTLO) begin
                    lo_d = ex.rs_val;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    logic [31:0] alu_out_q, dm_wdata_q, pc_q;
    logic [4:0]  waddr_q;
    logic [2:0]  tnew_q;

    // A stalled md op leaves a bubble that keeps its PC so the slot stays traceable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_q  <= '0;
            dm_wdata_q <= '0;
            pc_q       <= RESET_PC;
            waddr_q    <= '0;
            tnew_q     <= '0;
        end else if (stall) begin
            alu_out_q  <= '0;
            dm_wdata_q <= '0;
            pc_q       <= ex.pc_in;
            waddr_q    <= '0;
            tnew_q     <= '0;
        end else begin
            alu_out_q  <= alu_res;
            dm_wdata_q <= ex.dm_wdata_in;
            pc_q       <= ex.pc_in;
            waddr_q    <= ex.waddr_in;
            tnew_q     <= (ex.tnew_in != 3'd0) ? ex.tnew_in - 3'd1 : 3'd0;
        end
    end

    assign ex.alu_out_ex_to_mem  = alu_out_q;
    assign ex.dm_wdata_ex_to_mem = dm_wdata_q;
    assign ex.pc_ex_to_mem       = pc_q;
    assign ex.waddr_ex_to_mem    = waddr_q;
    assign ex.tnew_ex_to_mem     = tnew_q;
    assign ex.md_busy            = (state_q == MD_RUN);
    assign ex.md_stall           = stall;
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Bench for ex_stage_muldiv: directed vectors checked against a behavioural model on every negedge,
// plus literal expectations from hand arithmetic.
module tb_ex_stage_muldiv;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [3:0] NOP = 4'd0, ADDU = 4'd1, SUBU = 4'd2, ORR = 4'd3, LUI = 4'd4, SLL = 4'd5,
                           LINK = 4'd6, MULT = 4'd7, MULTU = 4'd8, DIV = 4'd9, DIVU = 4'd10,
                           MFHI = 4'd11, MFLO = 4'd12, MTHI = 4'd13, MTLO = 4'd14;

    logic clk = 1'b0;
    logic reset;
    ex_stage_muldiv_if ifc ();

    ex_stage_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-busy-cycles count and pending HI/LO.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_wr = 1'b0;
    int          m_left = 0;
    logic [31:0] e_alu = '0, e_dm = '0, e_pc = 32'h3000;
    logic [4:0]  e_wa = '0;
    logic [2:0]  e_tn = '0;

    always @(posedge clk or posedge reset) begin : model
        logic [31:0] a, b, res;
        logic [63:0] prod;
        longint      sq, sr;
        bit          md;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0;
            e_alu = '0; e_dm = '0; e_pc = 32'h3000; e_wa = '0; e_tn = '0;
        end else begin
            a = ifc.rs_val;
            b = ifc.src_b_imm ? ifc.imm32 : ifc.rt_val;
            case (ifc.op)
                ADDU:    res = a + b;
                SUBU:    res = a - b;
                ORR:     res = a | b;
                LUI:     res = b << 16;
                SLL:     res = ifc.rt_val << ifc.shamt;
                LINK:    res = ifc.pc_in + 32'd8;
                MFHI:    res = m_hi;
                MFLO:    res = m_lo;
                default: res = '0;
            endcase
            md = (ifc.op >= MULT) && (ifc.op <= MTLO);
            if (md && m_left > 0) begin
                e_alu = '0; e_dm = '0; e_wa = '0; e_tn = '0; e_pc = ifc.pc_in;
            end else begin
                e_alu = res; e_dm = ifc.dm_wdata_in; e_wa = ifc.waddr_in; e_pc = ifc.pc_in;
                e_tn  = (ifc.tnew_in == 3'd0) ? 3'd0 : ifc.tnew_in - 3'd1;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            end else begin
                case (ifc.op)
                    MULT: begin
                        prod = 64'(longint'($signed(a)) * longint'($signed(b)));
                        {p_hi, p_lo} = prod; p_wr = 1'b1; m_left = MULT_N;
                    end
                    MULTU: begin
                        prod = 64'(longint'({32'h0, a}) * longint'({32'h0, b}));
                        {p_hi, p_lo} = prod; p_wr = 1'b1; m_left = MULT_N;
                    end
                    DIV: begin
                        p_wr = (b != 0); m_left = DIV_N;
                        if (b != 0) begin
                            sq = longint'($signed(a)) / longint'($signed(b));
                            sr = longint'($signed(a)) % longint'($signed(b));
                            p_lo = sq[31:0]; p_hi = sr[31:0];
                        end
                    end
                    DIVU: begin
                        p_wr = (b != 0); m_left = DIV_N;
                        if (b != 0) begin p_lo = a / b; p_hi = a % b; end
                    end
                    MTHI: m_hi = a;
                    MTLO: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("alu_out", ifc.alu_out_ex_to_mem, e_alu);
        check("dm_wdata", ifc.dm_wdata_ex_to_mem, e_dm);
        check("pc", ifc.pc_ex_to_mem, e_pc);
        check("waddr", 32'(ifc.waddr_ex_to_mem), 32'(e_wa));
        check("tnew", 32'(ifc.tnew_ex_to_mem), 32'(e_tn));
        check("md_busy", 32'(ifc.md_busy), 32'(m_left > 0));
        check("md_stall", 32'(ifc.md_stall),
              32'((ifc.op >= MULT) && (ifc.op <= MTLO) && (m_left > 0)));
    end

    logic [31:0] pc_ctr = 32'h0000_3100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [2:0] tn);
        ifc.op = o; ifc.rs_val = a; ifc.rt_val = b; ifc.imm32 = 32'h5A5A_0000;
        ifc.src_b_imm = 1'b0; ifc.shamt = 5'd0; ifc.pc_in = pc_ctr;
        ifc.waddr_in = wa; ifc.tnew_in = tn; ifc.dm_wdata_in = a ^ b;
        pc_ctr = pc_ctr + 32'd4;
    endtask

    // Hold the current op while it is stalled; returns the number of stalled cycles.
    task automatic wait_unstall(output int n);
        n = 0;
        #1;
        while (ifc.md_stall === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: got %0d stalled cycles expected fewer than 50", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        set_op(NOP, 0, 0, 0, 0);
        #2;
        check("rst_pc", ifc.pc_ex_to_mem, 32'h0000_3000);
        check("rst_alu", ifc.alu_out_ex_to_mem, 32'h0);
        check("rst_busy", 32'(ifc.md_busy), 32'h0);
        tick();
        reset = 1'b0;

        set_op(ADDU, 32'hFFFF_FFFF, 32'h1, 5'd5, 3'd2); tick();
        check("addu_wrap", ifc.alu_out_ex_to_mem, 32'h0);
        check("addu_waddr", 32'(ifc.waddr_ex_to_mem), 32'd5);
        check("addu_tnew", 32'(ifc.tnew_ex_to_mem), 32'd1);

        set_op(LINK, 0, 0, 5'd31, 3'd3); ifc.pc_in = 32'h0000_3004; tick();
        check("link", ifc.alu_out_ex_to_mem, 32'h0000_300C);

        set_op(ORR, 32'h0F00_000F, 0, 5'd3, 3'd1); ifc.src_b_imm = 1'b1; ifc.imm32 = 32'h0000_F0F0; tick();
        check("or_imm", ifc.alu_out_ex_to_mem, 32'h0F00_F0FF);

        set_op(LUI, 0, 0, 5'd4, 3'd1); ifc.src_b_imm = 1'b1; ifc.imm32 = 32'hFFFF_1234; tick();
        check("lui", ifc.alu_out_ex_to_mem, 32'h1234_0000);

        set_op(SLL, 0, 32'h3, 5'd6, 3'd1); ifc.shamt = 5'd31; tick();
        check("sll", ifc.alu_out_ex_to_mem, 32'h8000_0000);

        set_op(SUBU, 0, 32'h1, 5'd7, 3'd0); tick();
        check("subu", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFF);
        check("tnew_floor", 32'(ifc.tnew_ex_to_mem), 32'd0);

        // MULT -3 * 7, then MFHI/MFLO
        set_op(MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 3'd0); tick();
        check("mult_busy", 32'(ifc.md_busy), 32'd1);
        set_op(MFHI, 0, 0, 5'd8, 3'd2); wait_unstall(n);
        check("mfhi_stalls", 32'(n), 32'd5);
        tick();
        check("mult_hi", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFF);
        set_op(MFLO, 0, 0, 5'd9, 3'd2); tick();
        check("mult_lo", ifc.alu_out_ex_to_mem, 32'hFFFF_FFEB);

        // DIV -7 / 2
        set_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 3'd0); tick();
        set_op(MFLO, 0, 0, 5'd9, 3'd2); wait_unstall(n);
        check("div_stalls", 32'(n), 32'd10);
        tick();
        check("div_lo", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFD);
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("div_hi", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFF);

        // DIVU by zero leaves HI/LO alone
        set_op(DIVU, 32'd7, 32'd0, 5'd0, 3'd0); tick();
        set_op(MFLO, 0, 0, 5'd9, 3'd2); wait_unstall(n);
        check("divz_stalls", 32'(n), 32'd10);
        tick();
        check("divz_lo", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFD);
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("divz_hi", ifc.alu_out_ex_to_mem, 32'hFFFF_FFFF);

        // Most-negative / -1
        set_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 3'd0); tick();
        set_op(MFLO, 0, 0, 5'd9, 3'd2); wait_unstall(n); tick();
        check("divovf_lo", ifc.alu_out_ex_to_mem, 32'h8000_0000);
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("divovf_hi", ifc.alu_out_ex_to_mem, 32'h0);

        // Non-md op passes during busy; MTLO waits
        set_op(MULT, 32'd2, 32'd3, 5'd0, 3'd0); tick();
        set_op(ADDU, 32'd10, 32'd20, 5'd9, 3'd1); #1;
        check("addu_nostall", 32'(ifc.md_stall), 32'd0);
        tick();
        check("addu_busy", ifc.alu_out_ex_to_mem, 32'd30);
        set_op(MTLO, 32'hCAFE_BABE, 0, 5'd0, 3'd0); wait_unstall(n);
        check("mtlo_stalls", 32'(n), 32'd4);
        tick();
        set_op(MFLO, 0, 0, 5'd9, 3'd2); tick();
        check("mtlo_lo", ifc.alu_out_ex_to_mem, 32'hCAFE_BABE);
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("mult23_hi", ifc.alu_out_ex_to_mem, 32'h0);

        set_op(MTHI, 32'h1234_5678, 0, 5'd0, 3'd0); tick();
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("mthi", ifc.alu_out_ex_to_mem, 32'h1234_5678);

        // Back-to-back MULTU
        set_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 3'd0); tick();
        set_op(MULTU, 32'd2, 32'd3, 5'd0, 3'd0); wait_unstall(n);
        check("b2b_stalls", 32'(n), 32'd5);
        check("b2b_first_hi", dut.hi_q, 32'hFFFF_FFFE);
        check("b2b_first_lo", dut.lo_q, 32'h0000_0001);
        tick();
        set_op(MFHI, 0, 0, 5'd8, 3'd2); wait_unstall(n); tick();
        check("b2b_second_hi", ifc.alu_out_ex_to_mem, 32'h0);
        set_op(MFLO, 0, 0, 5'd9, 3'd2); tick();
        check("b2b_second_lo", ifc.alu_out_ex_to_mem, 32'd6);

        // Reset in the fourth busy cycle of a DIV
        set_op(ADDU, 32'd1, 32'd1, 5'd10, 3'd3); tick();
        set_op(DIV, 32'd100, 32'd7, 5'd0, 3'd0); tick();
        set_op(NOP, 0, 0, 5'd11, 3'd2); tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_alu", ifc.alu_out_ex_to_mem, 32'h0);
        check("mid_rst_pc", ifc.pc_ex_to_mem, 32'h0000_3000);
        check("mid_rst_waddr", 32'(ifc.waddr_ex_to_mem), 32'd0);
        check("mid_rst_tnew", 32'(ifc.tnew_ex_to_mem), 32'd0);
        check("mid_rst_busy", 32'(ifc.md_busy), 32'd0);
        tick();
        reset = 1'b0;
        set_op(MFHI, 0, 0, 5'd8, 3'd2); tick();
        check("rst_hi", ifc.alu_out_ex_to_mem, 32'h0);
        set_op(MFLO, 0, 0, 5'd9, 3'd2); tick();
        check("rst_lo", ifc.alu_out_ex_to_mem, 32'h0);

        set_op(NOP, 0, 0, 0, 0); tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
